// File: rtl/cmem_bus_arb.sv
// cmem_bus_arb: round-robin refill arbiter and write-invalidation broadcaster for N_PORTS cmem instances
//  clk, rst_n         clock, synchronous active-low reset
//  s_addr/s_rd        per-port refill line address and held request
//  s_rdata/s_dv       shared refill data, per-port one-cycle data-valid
//  m_addr/m_rd        memory line address and held read request
//  m_rdata/m_dv       memory line data and one-cycle data-valid
//  w_addr/w_vld       per-port written line address and notification pulse
//  w_stall            per-port invalidation slot occupied
//  inv_addr/inv       broadcast invalidation address and per-port strobe
`ifndef CMEM_BLK_LEN
`define CMEM_BLK_LEN 26
`endif
`ifndef CMEM_LINE
`define CMEM_LINE 128
`endif
module cmem_bus_arb #(
  parameter int N_PORTS = 2,
  parameter int BLK_LEN = `CMEM_BLK_LEN,
  parameter int LINE = `CMEM_LINE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_PORTS*BLK_LEN-1:0] s_addr,
  input  logic [N_PORTS-1:0]         s_rd,
  output logic [LINE-1:0]            s_rdata,
  output logic [N_PORTS-1:0]         s_dv,
  output logic [BLK_LEN-1:0]         m_addr,
  output logic                       m_rd,
  input  logic [LINE-1:0]            m_rdata,
  input  logic                       m_dv,
  input  logic [N_PORTS*BLK_LEN-1:0] w_addr,
  input  logic [N_PORTS-1:0]         w_vld,
  output logic [N_PORTS-1:0]         w_stall,
  output logic [BLK_LEN-1:0]         inv_addr,
  output logic [N_PORTS-1:0]         inv
);
  localparam int PW = $clog2(N_PORTS);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DRAIN = 2'd2;
  logic [1:0] state;
  logic [PW-1:0] gnt, rr_ptr, pick, sj;
  logic found, sv;
  logic [N_PORTS-1:0] slot_v;
  logic [BLK_LEN-1:0] slot_a [N_PORTS];
  // scanning downward leaves the first requester after rr_ptr as the winner
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int k = N_PORTS; k >= 1; k--) begin
      if (s_rd[(int'(rr_ptr) + k) % N_PORTS]) begin
        found = 1'b1;
        pick = PW'((int'(rr_ptr) + k) % N_PORTS);
      end
    end
  end
  assign s_rdata = m_rdata;
  assign s_dv = (rst_n && state == BUSY && m_dv) ? N_PORTS'(1) << gnt : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      m_rd <= 1'b0;
      m_addr <= '0;
      gnt <= '0;
      rr_ptr <= PW'(N_PORTS - 1);
    end else begin
      case (state)
        IDLE: if (found) begin
          gnt <= pick;
          m_addr <= s_addr[int'(pick)*BLK_LEN +: BLK_LEN];
          m_rd <= 1'b1;
          state <= BUSY;
        end
        BUSY: if (m_dv) begin
          m_rd <= 1'b0;
          rr_ptr <= gnt;
          state <= IDLE;
        end else if (!s_rd[gnt]) state <= DRAIN;
        DRAIN: if (m_dv) begin
          m_rd <= 1'b0;
          rr_ptr <= gnt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    sj = '0;
    sv = 1'b0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (slot_v[k]) begin
        sv = 1'b1;
        sj = PW'(k);
      end
    end
  end
  assign w_stall = slot_v;
  // an occupied slot ignores w_vld, so a same-cycle serve never picks up the new notification
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_v <= '0;
      inv <= '0;
      inv_addr <= '0;
    end else begin
      inv <= sv ? ~(N_PORTS'(1) << sj) : '0;
      if (sv) inv_addr <= slot_a[sj];
      for (int i = 0; i < N_PORTS; i++) begin
        if (slot_v[i]) begin
          if (sv && int'(sj) == i) slot_v[i] <= 1'b0;
        end else if (w_vld[i]) begin
          slot_v[i] <= 1'b1;
          slot_a[i] <= w_addr[i*BLK_LEN +: BLK_LEN];
        end
      end
    end
  end
endmodule

// File: tb/tb_cmem_bus_arb.sv
// tb_cmem_bus_arb: vector table, corner sequences and randomized model check of cmem_bus_arb
module tb_cmem_bus_arb;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [23:0] s_addr = '0, w_addr = '0;
  logic [1:0] s_rd = '0, w_vld = '0, s_dv, w_stall, inv;
  logic [31:0] s_rdata, m_rdata = '0;
  logic [11:0] m_addr, inv_addr;
  logic m_rd, m_dv = 1'b0;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  cmem_bus_arb #(.N_PORTS(2), .BLK_LEN(12), .LINE(32)) dut (
    .clk(clk), .rst_n(rst_n), .s_addr(s_addr), .s_rd(s_rd), .s_rdata(s_rdata), .s_dv(s_dv),
    .m_addr(m_addr), .m_rd(m_rd), .m_rdata(m_rdata), .m_dv(m_dv), .w_addr(w_addr), .w_vld(w_vld),
    .w_stall(w_stall), .inv_addr(inv_addr), .inv(inv)
  );
  typedef struct {
    logic [1:0] rd, wv;
    logic [11:0] a0, a1, wa0, wa1;
    logic mrd;
    logic [11:0] ma;
    logic [1:0] i1;
    logic [11:0] ia1;
    logic [1:0] i2;
    logic [11:0] ia2;
  } vec_t;
  vec_t tbl [6];
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    s_rd = '0;
    w_vld = '0;
    m_dv = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask
  bit mb, drp;
  int own, last, memcnt;
  logic [11:0] maddr_m, eia;
  logic [11:0] pa [2];
  logic [11:0] ra [2];
  logic [1:0] pend, einv, esdv, old, rd_v, wv_v;
  bit req [2];
  bit cool [2];
  bit mdv, fnd;
  initial begin
    tbl[0] = '{2'b00, 2'b00, 12'h000, 12'h000, 12'h000, 12'h000, 1'b0, 12'h000, 2'b00, 12'h000, 2'b00, 12'h000};
    tbl[1] = '{2'b01, 2'b01, 12'h1A0, 12'h000, 12'h040, 12'h000, 1'b1, 12'h1A0, 2'b10, 12'h040, 2'b00, 12'h040};
    tbl[2] = '{2'b10, 2'b10, 12'h000, 12'h2B0, 12'h000, 12'h080, 1'b1, 12'h2B0, 2'b01, 12'h080, 2'b00, 12'h080};
    tbl[3] = '{2'b11, 2'b11, 12'h111, 12'h222, 12'h040, 12'h080, 1'b1, 12'h111, 2'b10, 12'h040, 2'b01, 12'h080};
    tbl[4] = '{2'b11, 2'b11, 12'hABC, 12'hFFF, 12'hFFF, 12'h000, 1'b1, 12'hABC, 2'b10, 12'hFFF, 2'b01, 12'h000};
    tbl[5] = '{2'b10, 2'b00, 12'h123, 12'hFFF, 12'h000, 12'h000, 1'b1, 12'hFFF, 2'b00, 12'h000, 2'b00, 12'h000};
    do_reset();
    chk("rst m_rd", m_rd, 0);
    chk("rst m_addr", m_addr, 0);
    chk("rst s_dv", s_dv, 0);
    chk("rst inv", inv, 0);
    chk("rst inv_addr", inv_addr, 0);
    chk("rst w_stall", w_stall, 0);
    for (int v = 0; v < 6; v++) begin
      do_reset();
      s_rd = tbl[v].rd;
      s_addr = {tbl[v].a1, tbl[v].a0};
      w_vld = tbl[v].wv;
      w_addr = {tbl[v].wa1, tbl[v].wa0};
      tick();
      s_rd = '0;
      w_vld = '0;
      #1;
      chk($sformatf("tbl%0d m_rd", v), m_rd, tbl[v].mrd);
      chk($sformatf("tbl%0d m_addr", v), m_addr, tbl[v].ma);
      tick();
      chk($sformatf("tbl%0d inv1", v), inv, tbl[v].i1);
      chk($sformatf("tbl%0d inv_addr1", v), inv_addr, tbl[v].ia1);
      tick();
      chk($sformatf("tbl%0d inv2", v), inv, tbl[v].i2);
      chk($sformatf("tbl%0d inv_addr2", v), inv_addr, tbl[v].ia2);
    end
    do_reset();
    s_rd = 2'b01;
    s_addr = {12'h000, 12'h1A0};
    #1;
    chk("single m_rd early", m_rd, 0);
    tick();
    chk("single m_rd", m_rd, 1);
    chk("single m_addr", m_addr, 12'h1A0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("single wait s_dv", s_dv, 0);
      chk("single wait m_rd", m_rd, 1);
    end
    m_dv = 1'b1;
    m_rdata = 32'hDEADBEEF;
    #1;
    chk("single s_dv", s_dv, 2'b01);
    chk("single s_rdata", s_rdata, 32'hDEADBEEF);
    tick();
    m_dv = 1'b0;
    s_rd = '0;
    #1;
    chk("single m_rd done", m_rd, 0);
    do_reset();
    s_rd = 2'b11;
    s_addr = {12'h200, 12'h100};
    for (int t = 0; t < 4; t++) begin
      tick();
      s_rd = 2'b11;
      #1;
      chk($sformatf("rr%0d m_rd", t), m_rd, 1);
      chk($sformatf("rr%0d m_addr", t), m_addr, (t % 2 == 0) ? 12'h100 : 12'h200);
      tick();
      tick();
      m_dv = 1'b1;
      #1;
      chk($sformatf("rr%0d s_dv", t), s_dv, (t % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      m_dv = 1'b0;
      s_rd[t % 2] = 1'b0;
      #1;
      chk($sformatf("rr%0d idle", t), m_rd, 0);
    end
    do_reset();
    s_rd = 2'b10;
    s_addr = {12'h333, 12'h055};
    tick();
    chk("abort m_addr", m_addr, 12'h333);
    tick();
    s_rd = 2'b00;
    tick();
    chk("abort drain m_rd", m_rd, 1);
    tick();
    m_dv = 1'b1;
    #1;
    chk("abort s_dv", s_dv, 0);
    tick();
    m_dv = 1'b0;
    #1;
    chk("abort m_rd low", m_rd, 0);
    s_rd = 2'b11;
    tick();
    chk("abort next m_rd", m_rd, 1);
    chk("abort next m_addr", m_addr, 12'h055);
    do_reset();
    w_vld = 2'b01;
    w_addr = {12'h000, 12'h011};
    #1;
    chk("stall first", w_stall, 0);
    tick();
    w_addr = {12'h000, 12'h022};
    #1;
    chk("stall second", w_stall, 2'b01);
    tick();
    w_vld = '0;
    #1;
    chk("stall inv", inv, 2'b10);
    chk("stall inv_addr", inv_addr, 12'h011);
    chk("stall cleared", w_stall, 0);
    tick();
    chk("stall dropped", inv, 0);
    do_reset();
    s_rd = 2'b01;
    w_vld = 2'b11;
    tick();
    w_vld = '0;
    #1;
    chk("rstb m_rd", m_rd, 1);
    chk("rstb w_stall", w_stall, 2'b11);
    rst_n = 1'b0;
    m_dv = 1'b1;
    #1;
    chk("rstb s_dv in rst", s_dv, 0);
    tick();
    rst_n = 1'b1;
    m_dv = 1'b0;
    s_rd = '0;
    #1;
    chk("rstb m_rd", m_rd, 0);
    chk("rstb inv", inv, 0);
    chk("rstb w_stall", w_stall, 0);
    tick();
    chk("rstb no stale inv", inv, 0);
    do_reset();
    mb = 0; drp = 0; own = 0; last = 1; memcnt = 2;
    maddr_m = '0; eia = '0; pend = '0; einv = '0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0;
      cool[i] = 0;
      ra[i] = '0;
      pa[i] = '0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      mdv = 0;
      if (m_rd) begin
        if (memcnt == 0) begin
          mdv = 1;
          memcnt = $urandom_range(4);
        end else memcnt--;
      end else if ($urandom_range(9) == 0) mdv = 1;
      for (int i = 0; i < 2; i++) begin
        if (req[i]) begin
          if (!mdv && $urandom_range(29) == 0) req[i] = 0;
        end else if (!cool[i] && $urandom_range(2) == 0) begin
          req[i] = 1;
          ra[i] = 12'($urandom);
        end
        cool[i] = 0;
        rd_v[i] = req[i];
        s_addr[i*12 +: 12] = ra[i];
      end
      wv_v = 2'($urandom) & 2'($urandom);
      s_rd = rd_v;
      w_vld = wv_v;
      w_addr = 24'($urandom);
      m_dv = mdv;
      m_rdata = $urandom;
      #1;
      esdv = (mb && !drp && mdv) ? 2'(1 << own) : 2'b00;
      chk("rnd m_rd", m_rd, mb);
      chk("rnd m_addr", m_addr, maddr_m);
      chk("rnd s_dv", s_dv, esdv);
      chk("rnd w_stall", w_stall, pend);
      chk("rnd inv", inv, einv);
      chk("rnd inv_addr", inv_addr, eia);
      for (int i = 0; i < 2; i++) if (esdv[i]) begin
        req[i] = 0;
        cool[i] = 1;
      end
      if (!mb) begin
        fnd = 0;
        for (int k = 1; k <= 2; k++) begin
          if (!fnd && rd_v[(last + k) % 2]) begin
            fnd = 1;
            own = (last + k) % 2;
            mb = 1;
            drp = 0;
            maddr_m = ra[own];
          end
        end
      end else if (mdv) begin
        mb = 0;
        last = own;
      end else if (!rd_v[own]) drp = 1;
      old = pend;
      einv = '0;
      fnd = 0;
      for (int j = 0; j < 2; j++) begin
        if (!fnd && old[j]) begin
          fnd = 1;
          einv = ~2'(1 << j);
          eia = pa[j];
          pend[j] = 0;
        end
      end
      for (int i = 0; i < 2; i++) if (!old[i] && wv_v[i]) begin
        pend[i] = 1;
        pa[i] = w_addr[i*12 +: 12];
      end
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
